rv_lsu_ctrl: RTL and testbench
==============================

Name: rv_lsu_ctrl

Overview:
Load/store sequencer placed after the ALU execute stage.
- Takes the computed address, store data and byte selects for one memory instruction.
- Runs a request/acknowledge transaction on the data bus and stalls the pipeline until it completes.
- Returns aligned, sign/zero-extended load data to write-back.
- Detects misaligned accesses and bus timeouts and reports both as trap causes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles REQ may wait for i_dbus_ack before aborting; legal range 1..65535.
- TO_WIDTH, 16: width of the timeout counter.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_flush  in  1  pipeline flush
- i_load  in  1  memory read request this cycle
- i_store  in  1  memory write request this cycle
- i_addr  in  32  byte address (ALU adder result)
- i_wdata  in  32  lane-replicated store data
- i_wsel  in  4  store byte enables
- i_funct3  in  3  access size/sign (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU)
- i_rd  in  5  load destination register
- o_stall  out  1  hold upstream stages
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  write enable
- o_dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dbus_wdata  out  32  store data
- o_dbus_sel  out  4  byte enables (4'b1111 for loads)
- i_dbus_ack  in  1  transfer done; rdata valid this cycle
- i_dbus_rdata  in  32  read data
- o_done  out  1  access retired
- o_ld_valid  out  1  o_ld_data/o_rd carry a register write
- o_ld_data  out  32  extended load data
- o_rd  out  5  destination register
- o_misaligned  out  1  misaligned access pulse
- o_bus_err  out  1  timeout pulse
- o_trap_addr  out  32  faulting byte address

Behaviour:
- Clock/reset: one clock i_clk; reset is synchronous, active-low (i_reset_n).
- Reset values: state IDLE; all outputs 0.
- Reset mid-transaction: next edge forces IDLE and drops o_dbus_req; a late ack is ignored.
- States: IDLE, REQ.
- Accepting an access (IDLE): access = i_load|i_store.
  - Misalignment: (funct3[1:0]==1 & addr[0]) | (funct3[1:0]==2 & addr[1:0]!=0).
  - Flush: an access with i_flush high is dropped; no outputs.
  - Misaligned access: stays IDLE, o_stall=0, no bus request; next cycle o_misaligned=1 and o_trap_addr=i_addr for one cycle.
  - Aligned access: load the bus registers, record load/rd/funct3/addr[1:0], clear the timeout counter, go to REQ.
- Stall: o_stall combinational = (IDLE & aligned access & !i_flush) | REQ.
- Latency: access presented in cycle N → o_dbus_req from N+1 until the ack cycle M inclusive → o_done at M+1. Minimum total is 2 cycles (ack at N+1).
- REQ, on i_dbus_ack:
  - Go to IDLE.
  - For a load: select lane by addr[1:0] (byte) or addr[1] (half), sign-extend for funct3 0/1, zero-extend for 4/5, register into o_ld_data.
  - o_done=1 for one cycle; o_ld_valid = load & rd!=0.
- REQ, no ack: counter increments. When it reaches TIMEOUT_CYCLES, go to IDLE, drop req, and pulse o_bus_err the next cycle with o_trap_addr = recorded address; no o_done.
- Flush during REQ: the transaction is not aborted and req holds until ack or timeout. A kill flag suppresses o_done, o_ld_valid and o_bus_err. Stores still commit on the bus.
- Ack in IDLE: ignored.
- Simultaneous events:
  - i_load & i_store together: treated as a store.
  - After o_done, a new access may be accepted on the same cycle o_done is high (back-to-back, one bubble-free IDLE cycle).
- Bus hold rule: bus outputs stay stable while o_dbus_req=1.
- Pulse timing: o_done, o_misaligned and o_bus_err are registered single-cycle pulses and are mutually exclusive.

Decomposition:
- Shared package (rv_structs.vh / rv_defines.vh):
  - lsu_state_t enum {IDLE, REQ}
  - funct3 size/sign constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - trap cause codes (load/store misaligned, load/store access fault)
- Sub-module rv_lsu_extend: combinational lane select plus sign/zero extension (rdata, addr[1:0], funct3 → 32-bit).

Test Plan:
- LW at 0x100, ack 3 cycles after req → o_dbus_addr=0x100, sel=4'b1111, o_stall high 4 cycles; o_done with o_ld_data=rdata, o_rd echoed.
- LB at 0x103, rdata=0x80FF_FF00 → o_ld_data=0xFFFF_FF80; LBU same → 0x0000_0080; LH at 0x102, rdata 0x8001_0000 → 0xFFFF_8001.
- SH at 0x202, wdata 0x1234_1234, wsel 4'b1100, ack next cycle → we=1, o_dbus_addr=0x200, sel=4'b1100; o_done=1, o_ld_valid=0.
- LW at 0x101 → no req, o_stall=0; next cycle o_misaligned=1, o_trap_addr=0x101.
- TIMEOUT_CYCLES=4, no ack → req drops after 4 REQ cycles; o_bus_err=1 once; following load accepted normally.
- Flush one cycle after a store is issued, ack 2 cycles later → store seen on bus, no o_done. Reset asserted mid-REQ → req=0 on the next edge; later ack ignored.

Source files
------------

// File: rtl/rv_lsu_ctrl_pkg.sv
// Shared LSU types: FSM states, funct3 size codes, trap causes.
// Also holds the alignment rule used when an access is accepted.
package rv_lsu_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef struct packed {
    logic        load;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] addr;
  } lsu_rec_t;

  function automatic logic lsu_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'd1) && a[0]) ||
           ((f3[1:0] == 2'd2) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/rv_lsu_ctrl_extend.sv
// Load lane select and sign/zero extension.
// Ports: rdata (bus word), addr_lo, funct3 in; data (32-bit) out.
module rv_lsu_extend
  import rv_lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = rdata[{addr_lo[1], 4'b0000} +: 16];
    data = rdata;
    unique case (1'b1)
      funct3 == LSU_B:  data = {{24{b[7]}}, b};
      funct3 == LSU_BU: data = {24'd0, b};
      funct3 == LSU_H:  data = {{16{h[15]}}, h};
      funct3 == LSU_HU: data = {16'd0, h};
      default:          data = rdata;
    endcase
  end

endmodule

// File: rtl/rv_lsu_ctrl.sv
// Load/store sequencer: one req/ack bus transfer per access,
// pipeline stall, load extension, misalign and timeout traps.
module rv_lsu_ctrl
  import rv_lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_sel,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_done,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic [4:0]  o_rd,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic [31:0] o_trap_addr
);

  localparam logic [TO_WIDTH-1:0] TO_MAX =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  lsu_state_t          state_q;
  lsu_state_t          state_d;
  lsu_rec_t            rec_q;
  logic [TO_WIDTH-1:0] cnt_q;
  logic                kill_q;

  logic        access;
  logic        mis;
  logic        take;
  logic        mis_evt;
  logic        ack_evt;
  logic        to_evt;
  logic        kill_now;
  logic [31:0] ext;

  rv_lsu_extend u_ext (
    .rdata   (i_dbus_rdata),
    .addr_lo (rec_q.addr[1:0]),
    .funct3  (rec_q.funct3),
    .data    (ext)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    access  = i_load | i_store;
    mis     = lsu_misaligned(i_funct3, i_addr[1:0]);
    take    = 1'b0;
    mis_evt = 1'b0;
    ack_evt = 1'b0;
    to_evt  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (access && !i_flush) begin
          if (mis) begin
            mis_evt = 1'b1;
          end else begin
            take    = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_dbus_ack) begin
          ack_evt = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_MAX) begin
          to_evt  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush arriving on the completing cycle also kills it.
  assign kill_now   = kill_q | i_flush;
  assign o_stall    = take | (state_q == REQ);
  assign o_dbus_req = (state_q == REQ);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_dbus_we    <= 1'b0;
      o_dbus_addr  <= '0;
      o_dbus_wdata <= '0;
      o_dbus_sel   <= '0;
      o_done       <= 1'b0;
      o_ld_valid   <= 1'b0;
      o_ld_data    <= '0;
      o_rd         <= '0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      o_trap_addr  <= '0;
      rec_q        <= '0;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_ld_valid   <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      if (take) begin
        o_dbus_we    <= i_store;
        o_dbus_addr  <= {i_addr[31:2], 2'b00};
        o_dbus_wdata <= i_store ? i_wdata : 32'd0;
        o_dbus_sel   <= i_store ? i_wsel : 4'hf;
        rec_q.load   <= ~i_store;
        rec_q.rd     <= i_rd;
        rec_q.funct3 <= i_funct3;
        rec_q.addr   <= i_addr;
        cnt_q        <= '0;
        kill_q       <= 1'b0;
      end
      if (mis_evt) begin
        o_misaligned <= 1'b1;
        o_trap_addr  <= i_addr;
      end
      if (state_q == REQ) begin
        if (i_flush)     kill_q <= 1'b1;
        if (!i_dbus_ack) cnt_q  <= cnt_q + 1'b1;
      end
      if (ack_evt && !kill_now) begin
        o_done     <= 1'b1;
        o_ld_valid <= rec_q.load && (rec_q.rd != 5'd0);
        if (rec_q.load) begin
          o_ld_data <= ext;
          o_rd      <= rec_q.rd;
        end
      end
      if (to_evt && !kill_now) begin
        o_bus_err   <= 1'b1;
        o_trap_addr <= rec_q.addr;
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// Self-checking bench for rv_lsu_ctrl.
// Directed scenarios plus randomized accesses vs a reference model.
module tb_rv_lsu_ctrl;

  localparam int T   = 4;
  localparam int CYC = 8;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_load;
  logic        i_store;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wsel;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [31:0] o_dbus_wdata;
  logic [3:0]  o_dbus_sel;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;
  logic        o_done;
  logic        o_ld_valid;
  logic [31:0] o_ld_data;
  logic [4:0]  o_rd;
  logic        o_misaligned;
  logic        o_bus_err;
  logic [31:0] o_trap_addr;

  int checks = 0;
  int errors = 0;

  int          ob_stall, ob_req, ob_done, ob_done_k;
  int          ob_mis, ob_mis_k, ob_err, ob_err_k;
  logic        ob_ldv, ob_ldv_any, ob_unstable, ob_first;
  logic [31:0] ob_ld_data, ob_trap, ob_addr, ob_wdata;
  logic [4:0]  ob_rd;
  logic        ob_we;
  logic [3:0]  ob_sel;

  rv_lsu_ctrl #(.TIMEOUT_CYCLES(T), .TO_WIDTH(16)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_flush      (i_flush),
    .i_load       (i_load),
    .i_store      (i_store),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_wsel       (i_wsel),
    .i_funct3     (i_funct3),
    .i_rd         (i_rd),
    .o_stall      (o_stall),
    .o_dbus_req   (o_dbus_req),
    .o_dbus_we    (o_dbus_we),
    .o_dbus_addr  (o_dbus_addr),
    .o_dbus_wdata (o_dbus_wdata),
    .o_dbus_sel   (o_dbus_sel),
    .i_dbus_ack   (i_dbus_ack),
    .i_dbus_rdata (i_dbus_rdata),
    .o_done       (o_done),
    .o_ld_valid   (o_ld_valid),
    .o_ld_data    (o_ld_data),
    .o_rd         (o_rd),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_trap_addr  (o_trap_addr)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ref_ext(
    input logic [31:0] w,
    input logic [31:0] a,
    input logic [2:0]  f3
  );
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hff;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hffff_ff00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hffff;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hffff_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Drives one access and records what the DUT did over CYC cycles.
  // ack_at/flush_at: cycle index after the access cycle (0 = same).
  task automatic do_access(
    input logic        ld,
    input logic        st,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  wsel,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input int          ack_at,
    input int          flush_at,
    input logic [31:0] rdata
  );
    ob_stall = 0; ob_req = 0; ob_done = 0; ob_done_k = -1;
    ob_mis = 0; ob_mis_k = -1; ob_err = 0; ob_err_k = -1;
    ob_ldv = 0; ob_ldv_any = 0; ob_unstable = 0; ob_first = 1;
    ob_ld_data = '0; ob_trap = '0; ob_addr = '0; ob_wdata = '0;
    ob_rd = '0; ob_we = 0; ob_sel = '0;
    i_load = ld; i_store = st; i_addr = addr; i_wdata = wdata;
    i_wsel = wsel; i_funct3 = f3; i_rd = rd;
    i_dbus_ack = 0; i_flush = (flush_at == 0);
    i_dbus_rdata = rdata;
    #1;
    if (o_stall) ob_stall++;
    if (o_dbus_req) ob_req++;
    for (int k = 1; k <= CYC; k++) begin
      @(posedge i_clk); #1;
      i_load = 0; i_store = 0;
      i_dbus_ack = (k == ack_at);
      i_flush = (k == flush_at);
      if (o_ld_valid) ob_ldv_any = 1;
      if (o_done) begin
        ob_done++; ob_done_k = k; ob_ldv = o_ld_valid;
        ob_ld_data = o_ld_data; ob_rd = o_rd;
      end
      if (o_misaligned) begin
        ob_mis++; ob_mis_k = k; ob_trap = o_trap_addr;
      end
      if (o_bus_err) begin
        ob_err++; ob_err_k = k; ob_trap = o_trap_addr;
      end
      #1;
      if (o_stall) ob_stall++;
      if (o_dbus_req) begin
        ob_req++;
        if (ob_first) begin
          ob_first = 0; ob_addr = o_dbus_addr; ob_we = o_dbus_we;
          ob_sel = o_dbus_sel; ob_wdata = o_dbus_wdata;
        end else if (o_dbus_addr !== ob_addr || o_dbus_we !== ob_we ||
                     o_dbus_sel !== ob_sel || o_dbus_wdata !== ob_wdata) begin
          ob_unstable = 1;
        end
      end
    end
    i_dbus_ack = 0; i_flush = 0;
  endtask

  task automatic test_reset;
    checks++;
    if ({o_stall, o_dbus_req, o_dbus_we, o_done, o_ld_valid,
         o_misaligned, o_bus_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
        {o_stall, o_dbus_req, o_dbus_we, o_done, o_ld_valid,
         o_misaligned, o_bus_err});
    end
    checks++;
    if ({o_dbus_addr, o_dbus_wdata, o_dbus_sel, o_ld_data, o_rd,
         o_trap_addr} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got %h want 0",
        {o_dbus_addr, o_dbus_wdata, o_dbus_sel, o_ld_data, o_rd,
         o_trap_addr});
    end
  endtask

  task automatic test_lw;
    do_access(1, 0, 32'h100, 0, 0, 3'd2, 5'd7, 3, -1, 32'hdead_beef);
    checks++;
    if (ob_addr !== 32'h100 || ob_sel !== 4'hf || ob_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus: got %h/%h/%b want 100/f/0",
        ob_addr, ob_sel, ob_we);
    end
    checks++;
    if (ob_stall != 4 || ob_req != 3) begin
      errors++;
      $display("FAIL lw_stall: got stall %0d req %0d want 4 3",
        ob_stall, ob_req);
    end
    checks++;
    if (ob_done != 1 || ob_done_k != 4) begin
      errors++;
      $display("FAIL lw_done: got %0d at %0d want 1 at 4",
        ob_done, ob_done_k);
    end
    checks++;
    if (ob_ld_data !== 32'hdead_beef || ob_rd !== 5'd7 || !ob_ldv) begin
      errors++;
      $display("FAIL lw_data: got %h rd %0d v %b want deadbeef 7 1",
        ob_ld_data, ob_rd, ob_ldv);
    end
    checks++;
    if (ob_unstable) begin
      errors++;
      $display("FAIL lw_hold: got unstable bus want stable");
    end
  endtask

  task automatic test_lanes;
    do_access(1, 0, 32'h103, 0, 0, 3'd0, 5'd1, 1, -1, 32'h80ff_ff00);
    checks++;
    if (ob_ld_data !== 32'hffff_ff80) begin
      errors++;
      $display("FAIL lb: got %h want ffffff80", ob_ld_data);
    end
    do_access(1, 0, 32'h103, 0, 0, 3'd4, 5'd2, 1, -1, 32'h80ff_ff00);
    checks++;
    if (ob_ld_data !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu: got %h want 00000080", ob_ld_data);
    end
    do_access(1, 0, 32'h102, 0, 0, 3'd1, 5'd3, 1, -1, 32'h8001_0000);
    checks++;
    if (ob_ld_data !== 32'hffff_8001) begin
      errors++;
      $display("FAIL lh: got %h want ffff8001", ob_ld_data);
    end
    do_access(1, 0, 32'h102, 0, 0, 3'd5, 5'd0, 1, -1, 32'h8001_0000);
    checks++;
    if (ob_ld_data !== 32'h0000_8001 || ob_ldv !== 1'b0) begin
      errors++;
      $display("FAIL lhu_x0: got %h v %b want 00008001 0",
        ob_ld_data, ob_ldv);
    end
  endtask

  task automatic test_store;
    do_access(0, 1, 32'h202, 32'h1234_1234, 4'b1100, 3'd1, 5'd4,
              1, -1, 32'h0);
    checks++;
    if (ob_we !== 1'b1 || ob_addr !== 32'h200 || ob_sel !== 4'b1100 ||
        ob_wdata !== 32'h1234_1234) begin
      errors++;
      $display("FAIL sh_bus: got %b %h %b %h want 1 200 1100 12341234",
        ob_we, ob_addr, ob_sel, ob_wdata);
    end
    checks++;
    if (ob_done != 1 || ob_done_k != 2 || ob_ldv_any || ob_stall != 2) begin
      errors++;
      $display("FAIL sh_done: got d%0d k%0d v%b s%0d want 1 2 0 2",
        ob_done, ob_done_k, ob_ldv_any, ob_stall);
    end
  endtask

  task automatic test_misaligned;
    do_access(1, 0, 32'h101, 0, 0, 3'd2, 5'd5, 1, -1, 32'h0);
    checks++;
    if (ob_stall != 0 || ob_req != 0 || ob_done != 0) begin
      errors++;
      $display("FAIL mis_lw_quiet: got s%0d r%0d d%0d want 0 0 0",
        ob_stall, ob_req, ob_done);
    end
    checks++;
    if (ob_mis != 1 || ob_mis_k != 1 || ob_trap !== 32'h101) begin
      errors++;
      $display("FAIL mis_lw_pulse: got %0d at %0d addr %h want 1 1 101",
        ob_mis, ob_mis_k, ob_trap);
    end
    do_access(0, 1, 32'h203, 32'h5, 4'b1100, 3'd1, 5'd0, 1, -1, 32'h0);
    checks++;
    if (ob_mis != 1 || ob_req != 0 || ob_trap !== 32'h203) begin
      errors++;
      $display("FAIL mis_sh: got %0d req %0d addr %h want 1 0 203",
        ob_mis, ob_req, ob_trap);
    end
  endtask

  task automatic test_timeout;
    do_access(1, 0, 32'h300, 0, 0, 3'd2, 5'd6, 99, -1, 32'h0);
    checks++;
    if (ob_req != T || ob_done != 0) begin
      errors++;
      $display("FAIL to_req: got req %0d done %0d want %0d 0",
        ob_req, ob_done, T);
    end
    checks++;
    if (ob_err != 1 || ob_err_k != T + 1 || ob_trap !== 32'h300) begin
      errors++;
      $display("FAIL to_err: got %0d at %0d addr %h want 1 %0d 300",
        ob_err, ob_err_k, ob_trap, T + 1);
    end
    do_access(1, 0, 32'h304, 0, 0, 3'd2, 5'd6, 2, -1, 32'h0bad_f00d);
    checks++;
    if (ob_done != 1 || ob_ld_data !== 32'h0bad_f00d || ob_err != 0) begin
      errors++;
      $display("FAIL to_next: got d%0d %h e%0d want 1 0badf00d 0",
        ob_done, ob_ld_data, ob_err);
    end
  endtask

  task automatic test_flush;
    do_access(0, 1, 32'h400, 32'hcafe_0001, 4'hf, 3'd2, 5'd0,
              3, 1, 32'h0);
    checks++;
    if (ob_req != 3 || ob_we !== 1'b1 || ob_addr !== 32'h400 ||
        ob_wdata !== 32'hcafe_0001) begin
      errors++;
      $display("FAIL flush_st_bus: got r%0d we%b %h %h want 3 1 400 cafe0001",
        ob_req, ob_we, ob_addr, ob_wdata);
    end
    checks++;
    if (ob_done != 0 || ob_err != 0) begin
      errors++;
      $display("FAIL flush_st_done: got d%0d e%0d want 0 0",
        ob_done, ob_err);
    end
    do_access(1, 0, 32'h410, 0, 0, 3'd2, 5'd8, 1, 0, 32'h0);
    checks++;
    if (ob_stall != 0 || ob_req != 0 || ob_done != 0) begin
      errors++;
      $display("FAIL flush_accept: got s%0d r%0d d%0d want 0 0 0",
        ob_stall, ob_req, ob_done);
    end
  endtask

  task automatic test_reset_mid;
    i_store = 1; i_addr = 32'h500; i_funct3 = 3'd2;
    i_wsel = 4'hf; i_wdata = 32'h1;
    @(posedge i_clk); #1;
    i_store = 0;
    checks++;
    if (o_dbus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: got %b want 1", o_dbus_req);
    end
    i_reset_n = 0;
    @(posedge i_clk); #1;
    checks++;
    if (o_dbus_req !== 1'b0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: got req %b stall %b want 0 0",
        o_dbus_req, o_stall);
    end
    i_reset_n = 1; i_dbus_ack = 1;
    @(posedge i_clk); #1;
    i_dbus_ack = 0;
    checks++;
    if (o_done !== 1'b0 || o_dbus_req !== 1'b0 || o_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ack: got done %b req %b err %b want 0",
        o_done, o_dbus_req, o_bus_err);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r2;
    r2 = $urandom;
    i_load = 1; i_addr = 32'h600; i_funct3 = 3'd2; i_rd = 5'd3;
    @(posedge i_clk); #1;
    i_load = 0; i_dbus_ack = 1; i_dbus_rdata = 32'h1111_2222;
    @(posedge i_clk); #1;
    i_dbus_ack = 0;
    checks++;
    if (o_done !== 1'b1 || o_ld_data !== 32'h1111_2222) begin
      errors++;
      $display("FAIL b2b_first: got %b %h want 1 11112222",
        o_done, o_ld_data);
    end
    i_load = 1; i_addr = 32'h607; i_funct3 = 3'd4; i_rd = 5'd9;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: got %b want 1", o_stall);
    end
    @(posedge i_clk); #1;
    i_load = 0;
    checks++;
    if (o_dbus_req !== 1'b1 || o_dbus_addr !== 32'h604) begin
      errors++;
      $display("FAIL b2b_req: got %b %h want 1 604",
        o_dbus_req, o_dbus_addr);
    end
    i_dbus_ack = 1; i_dbus_rdata = r2;
    @(posedge i_clk); #1;
    i_dbus_ack = 0;
    checks++;
    if (o_done !== 1'b1 || o_ld_data !== ref_ext(r2, 32'h607, 3'd4) ||
        o_rd !== 5'd9) begin
      errors++;
      $display("FAIL b2b_second: got %b %h rd %0d want 1 %h 9",
        o_done, o_ld_data, o_rd, ref_ext(r2, 32'h607, 3'd4));
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random;
    logic        ld, st, mis, killed;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wsel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          ack_at, flush_at, r, reqs;
    int          e_stall, e_req, e_done, e_mis, e_err;
    int          f3tab[5];
    f3tab = '{0, 1, 2, 4, 5};
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom); st = 1'($urandom);
      if (!ld && !st) ld = 1;
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      wsel = 4'($urandom); rd = 5'($urandom);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'(f3tab[$urandom_range(0, 4)]);
      ack_at = $urandom_range(1, T + 2);
      r = $urandom_range(0, 7);
      flush_at = (r <= 4) ? -1 : r - 5;
      do_access(ld, st, addr, wdata, wsel, f3, rd, ack_at, flush_at, rdata);
      mis = ((f3 % 4 == 1) && (addr % 2 == 1)) ||
            ((f3 % 4 == 2) && (addr % 4 != 0));
      reqs = (ack_at <= T) ? ack_at : T;
      killed = (flush_at >= 1) && (flush_at <= reqs);
      e_stall = 0; e_req = 0; e_done = 0; e_mis = 0; e_err = 0;
      if (flush_at == 0) begin
      end else if (mis) begin
        e_mis = 1;
      end else begin
        e_stall = reqs + 1; e_req = reqs;
        if (ack_at <= T) e_done = killed ? 0 : 1;
        else             e_err  = killed ? 0 : 1;
      end
      checks++;
      if (ob_stall != e_stall || ob_req != e_req) begin
        errors++;
        $display("FAIL rnd%0d stall_req: got %0d %0d want %0d %0d",
          i, ob_stall, ob_req, e_stall, e_req);
      end
      checks++;
      if (ob_done != e_done || ob_mis != e_mis || ob_err != e_err) begin
        errors++;
        $display("FAIL rnd%0d pulses: got %0d %0d %0d want %0d %0d %0d",
          i, ob_done, ob_mis, ob_err, e_done, e_mis, e_err);
      end
      if (e_req > 0) begin
        checks++;
        if (ob_addr !== {addr[31:2], 2'b00} || ob_we !== st ||
            ob_sel !== (st ? wsel : 4'hf) ||
            (st && ob_wdata !== wdata) || ob_unstable) begin
          errors++;
          $display("FAIL rnd%0d bus: got %h %b %h %h u%b want %h %b",
            i, ob_addr, ob_we, ob_sel, ob_wdata, ob_unstable,
            {addr[31:2], 2'b00}, st);
        end
      end
      if (e_done == 1) begin
        checks++;
        if (ob_done_k != ack_at + 1 ||
            ob_ldv !== (!st && rd != 0) ||
            (!st && (ob_ld_data !== ref_ext(rdata, addr, f3) ||
                     ob_rd !== rd))) begin
          errors++;
          $display("FAIL rnd%0d load: got k%0d v%b %h rd%0d want k%0d %h rd%0d",
            i, ob_done_k, ob_ldv, ob_ld_data, ob_rd, ack_at + 1,
            ref_ext(rdata, addr, f3), rd);
        end
      end
      if (e_mis == 1 || e_err == 1) begin
        checks++;
        if (ob_trap !== addr ||
            (e_mis == 1 && ob_mis_k != 1) ||
            (e_err == 1 && ob_err_k != T + 1)) begin
          errors++;
          $display("FAIL rnd%0d trap: got %h mk%0d ek%0d want %h",
            i, ob_trap, ob_mis_k, ob_err_k, addr);
        end
      end
    end
  endtask

  initial begin
    i_reset_n = 0; i_flush = 0; i_load = 0; i_store = 0;
    i_addr = '0; i_wdata = '0; i_wsel = '0; i_funct3 = '0;
    i_rd = '0; i_dbus_ack = 0; i_dbus_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset;
    i_reset_n = 1;
    test_lw;
    test_lanes;
    test_store;
    test_misaligned;
    test_timeout;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
